ps2_hack_keyboard: RTL and testbench

- PS/2 keyboard receiver and decoder that sits upstream of hack_top's keyboard memory map (KBD, 0x6000).
- Samples the board's PS/2 clock/data lines, deframes 11-bit device-to-host frames and tracks E0/F0 prefixes and shift state.
- Translates scan-code set 2 into the Hack key code of the currently pressed key, or 0 when no mapped key is held.
- Runs in the PIXEL_CLK domain alongside hack_top.

---
 rtl/ps2_hack_keyboard.sv | 205 ++++++++++++++++++++
 tb/tb_ps2_hack_keyboard.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_hack_keyboard.sv
// PS/2 keyboard receiver: conditions the raw lines, deframes device-to-host frames and
// turns scan-code set 2 into the Hack key code of the held key (0 = none).
module ps2_hack_keyboard #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keycode,
  output logic        key_event,
  output logic        frame_error
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_filt;
  logic [FW-1:0] r_filt_cnt;
  state_e        r_state, w_state_d;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shreg, r_byte;
  logic          r_par, r_byte_vld, r_frame_error;
  logic [TW-1:0] r_to_cnt;
  logic [15:0]   r_keycode, w_keycode_d, w_xl, w_xl_alt;
  logic          r_key_event, r_ext, r_brk, r_shift;
  logic          w_ext_d, w_brk_d, w_shift_d;
  logic          w_fe, w_timeout, w_accept, w_err;

  function automatic logic [15:0] f_xlate(input logic [7:0] code, input logic ext,
                                          input logic shift);
    logic [15:0] v;
    v = 16'h0;
    if (ext) begin
      case (code)
        8'h6B: v = 16'd130;  8'h75: v = 16'd131;  8'h74: v = 16'd132;  8'h72: v = 16'd133;
        8'h6C: v = 16'd134;  8'h69: v = 16'd135;  8'h7D: v = 16'd136;  8'h7A: v = 16'd137;
        8'h70: v = 16'd138;  8'h71: v = 16'd139;
        default: v = 16'h0;
      endcase
    end else begin
      case (code)
        8'h1C: v = 16'h41;  8'h32: v = 16'h42;  8'h21: v = 16'h43;  8'h23: v = 16'h44;
        8'h24: v = 16'h45;  8'h2B: v = 16'h46;  8'h34: v = 16'h47;  8'h33: v = 16'h48;
        8'h43: v = 16'h49;  8'h3B: v = 16'h4A;  8'h42: v = 16'h4B;  8'h4B: v = 16'h4C;
        8'h3A: v = 16'h4D;  8'h31: v = 16'h4E;  8'h44: v = 16'h4F;  8'h4D: v = 16'h50;
        8'h15: v = 16'h51;  8'h2D: v = 16'h52;  8'h1B: v = 16'h53;  8'h2C: v = 16'h54;
        8'h3C: v = 16'h55;  8'h2A: v = 16'h56;  8'h1D: v = 16'h57;  8'h22: v = 16'h58;
        8'h35: v = 16'h59;  8'h1A: v = 16'h5A;
        8'h45: v = shift ? 16'h29 : 16'h30;  8'h16: v = shift ? 16'h21 : 16'h31;
        8'h1E: v = shift ? 16'h40 : 16'h32;  8'h26: v = shift ? 16'h23 : 16'h33;
        8'h25: v = shift ? 16'h24 : 16'h34;  8'h2E: v = shift ? 16'h25 : 16'h35;
        8'h36: v = shift ? 16'h5E : 16'h36;  8'h3D: v = shift ? 16'h26 : 16'h37;
        8'h3E: v = shift ? 16'h2A : 16'h38;  8'h46: v = shift ? 16'h28 : 16'h39;
        8'h29: v = 16'd32;   8'h5A: v = 16'd128;  8'h66: v = 16'd129;  8'h76: v = 16'd140;
        8'h05: v = 16'd141;  8'h06: v = 16'd142;  8'h04: v = 16'd143;  8'h0C: v = 16'd144;
        8'h03: v = 16'd145;  8'h0B: v = 16'd146;  8'h83: v = 16'd147;  8'h0A: v = 16'd148;
        8'h01: v = 16'd149;  8'h09: v = 16'd150;  8'h78: v = 16'd151;  8'h07: v = 16'd152;
        default: v = 16'h0;
      endcase
    end
    return v;
  endfunction

  // Lines idle high, so synchronizers and filter come out of reset at 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_filt     <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
      if (r_clk_s2 == r_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_filt     <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
    end
  end

  assign w_fe      = r_filt & ~r_clk_s2 & (r_filt_cnt == FW'(FILTER_LEN - 1));
  assign w_timeout = (r_state != StIdle) && !w_fe && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    w_err     = 1'b0;
    case (r_state)
      StIdle:   if (w_fe && !r_dat_s2) w_state_d = StData;
      StData:   if (w_fe && r_bit_cnt == 3'd7) w_state_d = StParity;
      StParity: if (w_fe) w_state_d = StStop;
      StStop: begin
        if (w_fe) begin
          w_state_d = StIdle;
          if (r_dat_s2 && ^{r_par, r_shreg}) w_accept = 1'b1;
          else                               w_err    = 1'b1;
        end
      end
      default:  w_state_d = StIdle;
    endcase
    if (w_timeout) begin
      w_state_d = StIdle;
      w_err     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt     <= '0;
      r_shreg       <= '0;
      r_par         <= 1'b0;
      r_to_cnt      <= '0;
      r_byte        <= '0;
      r_byte_vld    <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_byte_vld    <= w_accept;
      r_frame_error <= w_err;
      if (w_accept) r_byte <= r_shreg;
      if (w_fe || r_state == StIdle || w_timeout) r_to_cnt <= '0;
      else                                        r_to_cnt <= r_to_cnt + TW'(1);
      if (w_fe) begin
        case (r_state)
          StIdle:   r_bit_cnt <= '0;
          StData: begin
            r_shreg   <= {r_dat_s2, r_shreg[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          StParity: r_par <= r_dat_s2;
          default:  ;
        endcase
      end
    end
  end

  // Break matches either shift variant so releasing shift first still clears the key.
  assign w_xl     = f_xlate(r_byte, r_ext, r_shift);
  assign w_xl_alt = f_xlate(r_byte, r_ext, ~r_shift);

  always_comb begin
    w_keycode_d = r_keycode;
    w_ext_d     = r_ext;
    w_brk_d     = r_brk;
    w_shift_d   = r_shift;
    if (r_byte_vld) begin
      if (r_byte == 8'hE0) begin
        w_ext_d = 1'b1;
      end else if (r_byte == 8'hF0) begin
        w_brk_d = 1'b1;
      end else begin
        if (!r_ext && (r_byte == 8'h12 || r_byte == 8'h59)) begin
          w_shift_d = ~r_brk;
        end else if (w_xl != 16'h0) begin
          if (!r_brk)                                       w_keycode_d = w_xl;
          else if (w_xl == r_keycode || w_xl_alt == r_keycode) w_keycode_d = 16'h0;
        end
        w_ext_d = 1'b0;
        w_brk_d = 1'b0;
      end
    end
    if (w_err) begin
      w_ext_d = 1'b0;
      w_brk_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_keycode   <= '0;
      r_key_event <= 1'b0;
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_shift     <= 1'b0;
    end else begin
      r_keycode   <= w_keycode_d;
      r_key_event <= (w_keycode_d != r_keycode);
      r_ext       <= w_ext_d;
      r_brk       <= w_brk_d;
      r_shift     <= w_shift_d;
    end
  end

  assign keycode     = r_keycode;
  assign key_event   = r_key_event;
  assign frame_error = r_frame_error;

endmodule

// File: tb/tb_ps2_hack_keyboard.sv
// Directed bench for ps2_hack_keyboard: drives PS/2 frames and checks the outputs against
// a key-level model (held key identity, prefix flags, shift) plus literal expectations.
module tb_ps2_hack_keyboard;

  localparam int unsigned FILTER_LEN = 8;
  localparam int unsigned TIMEOUT    = 1000;
  localparam int          HALF       = 20;
  localparam int          GAP        = 40;

  localparam logic [7:0] LETTERS [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
    8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGITS  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] SHIFTED [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E,
    8'h26, 8'h2A, 8'h28};
  localparam logic [7:0] EXTS    [10] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D,
    8'h7A, 8'h70, 8'h71};
  localparam logic [7:0] FKEYS   [12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83,
    8'h0A, 8'h01, 8'h09, 8'h78, 8'h07};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] keycode;
  logic        key_event;
  logic        frame_error;

  int total = 0, passed = 0;
  int cyc = 0, fall_cyc = 0, err_cyc = 0, ev_cnt = 0, err_cnt = 0;
  bit chk_en = 1'b0;
  logic [15:0] prev_kc = 16'h0;
  logic        prev_fe = 1'b0;

  logic [15:0] m_kc = 16'h0;
  int          m_events = 0, m_errs = 0;
  bit          m_ext = 0, m_brk = 0, m_shift = 0, m_held = 0, m_held_ext = 0;
  logic [7:0]  m_held_sc = 8'h0;

  ps2_hack_keyboard #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .keycode    (keycode),
    .key_event  (key_event),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  function automatic int xlate(input logic [7:0] b, input bit ext, input bit sh);
    int r;
    r = 0;
    if (ext) begin
      for (int i = 0; i < 10; i++) if (b == EXTS[i]) r = 130 + i;
    end else begin
      for (int i = 0; i < 26; i++) if (b == LETTERS[i]) r = 65 + i;
      for (int i = 0; i < 10; i++) if (b == DIGITS[i]) r = sh ? int'(SHIFTED[i]) : 48 + i;
      for (int i = 0; i < 12; i++) if (b == FKEYS[i]) r = 141 + i;
      if (b == 8'h29) r = 32;
      if (b == 8'h5A) r = 128;
      if (b == 8'h66) r = 129;
      if (b == 8'h76) r = 140;
    end
    return r;
  endfunction

  // Model tracks which physical key produced the current code; a break clears only that key.
  task automatic model_byte(input logic [7:0] b);
    logic [15:0] nk;
    int code;
    nk = m_kc;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (!m_ext && (b == 8'h12 || b == 8'h59)) m_shift = !m_brk;
      else begin
        code = xlate(b, m_ext, m_shift);
        if (code != 0 && !m_brk) begin
          nk = 16'(code);
          m_held = 1; m_held_sc = b; m_held_ext = m_ext;
        end else if (code != 0 && m_held && b == m_held_sc && m_ext == m_held_ext) begin
          nk = 16'h0;
          m_held = 0;
        end
      end
      m_ext = 0;
      m_brk = 0;
    end
    if (nk != m_kc) m_events++;
    m_kc = nk;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_kc = 16'h0;
      prev_fe = 1'b0;
    end else begin
      if (key_event) ev_cnt++;
      if (frame_error) begin
        err_cnt++;
        err_cyc = cyc;
      end
      check("key_event_on_change", 32'(key_event), 32'(keycode != prev_kc));
      if (frame_error) check("frame_error_one_cycle", 32'(prev_fe), 0);
      if (chk_en) check("keycode_vs_model", 32'(keycode), 32'(m_kc));
      prev_kc = keycode;
      prev_fe = frame_error;
    end
  end

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b0;
      fall_cyc = cyc;
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par, stop;
    chk_en = 1'b0;
    par  = ~(^b) ^ bad_par;
    stop = ~bad_stop;
    send_bits({stop, par, b, 1'b0}, 11);
    repeat (GAP) @(posedge clk);
    if (bad_par || bad_stop) begin
      m_errs++;
      m_ext = 0;
      m_brk = 0;
    end else begin
      model_byte(b);
    end
    @(negedge clk);
    check("frame_keycode", 32'(keycode), 32'(m_kc));
    check("frame_events", ev_cnt, m_events);
    check("frame_errors", err_cnt, m_errs);
    chk_en = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  logic [7:0]  sweep_sc  [9] = '{8'h1A, 8'h1A, 8'h3D, 8'h07, 8'h83, 8'h66, 8'h76, 8'h29,
                                 8'h05};
  logic [15:0] sweep_exp [9] = '{16'h5A, 16'h5A, 16'h37, 16'd152, 16'd147, 16'd129, 16'd140,
                                 16'd32, 16'd141};

  initial begin
    int start_err, waited, delta;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_keycode", 32'(keycode), 0);
    check("reset_key_event", 32'(key_event), 0);
    check("reset_frame_error", 32'(frame_error), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    repeat (5) @(posedge clk);

    send_byte(8'h1C);
    check("A_make", 32'(keycode), 32'h41);
    check("A_make_events", ev_cnt, 1);
    send_byte(8'hF0); send_byte(8'h1C);
    check("A_break", 32'(keycode), 0);
    check("A_break_events", ev_cnt, 2);

    send_byte(8'hE0); send_byte(8'h75);
    check("up_make", 32'(keycode), 131);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check("up_break", 32'(keycode), 0);
    send_byte(8'h75);
    check("kp8_unmapped", 32'(keycode), 0);
    check("kp8_no_event", ev_cnt, 4);

    send_byte(8'h12); send_byte(8'h16);
    check("shift_1", 32'(keycode), 32'h21);
    send_byte(8'hF0); send_byte(8'h12);
    check("shift_release_hold", 32'(keycode), 32'h21);
    send_byte(8'hF0); send_byte(8'h16);
    check("shift_1_break", 32'(keycode), 0);

    send_byte(8'h1C); send_byte(8'h32);
    check("last_pressed_B", 32'(keycode), 32'h42);
    send_byte(8'hF0); send_byte(8'h1C);
    check("old_break_ignored", 32'(keycode), 32'h42);
    send_byte(8'hF0); send_byte(8'h32);

    send_byte(8'h45);
    send_frame(8'hF0, 1'b1, 1'b0);
    check("bad_parity_error", err_cnt, 1);
    check("bad_parity_hold", 32'(keycode), 32'h30);
    send_frame(8'h29, 1'b0, 1'b1);
    check("bad_stop_error", err_cnt, 2);
    send_byte(8'h29);
    check("space_make", 32'(keycode), 32);
    send_byte(8'hF0);
    send_frame(8'h1C, 1'b0, 1'b1);
    send_byte(8'h29);
    check("error_clears_brk", 32'(keycode), 32);
    check("error_clears_brk_events", ev_cnt, 11);

    for (int i = 0; i < 9; i++) begin
      send_byte(sweep_sc[i]);
      check("table_sweep", 32'(keycode), 32'(sweep_exp[i]));
    end
    send_byte(8'hE0); send_byte(8'h6B);
    check("ext_left", 32'(keycode), 130);
    send_byte(8'hE0); send_byte(8'h7D);
    check("ext_pgup", 32'(keycode), 136);
    send_byte(8'h12); send_byte(8'h1C);
    check("shift_letter_upper", 32'(keycode), 32'h41);
    send_byte(8'h26);
    check("shift_3", 32'(keycode), 32'h23);
    send_byte(8'hF0); send_byte(8'h12);
    send_byte(8'hF0); send_byte(8'h26);
    check("shift_3_break", 32'(keycode), 0);
    send_byte(8'hF0); send_byte(8'h1C);

    start_err = err_cnt;
    send_bits(11'b111_1111_0100, 4);
    waited = 0;
    while (err_cnt == start_err && waited < int'(TIMEOUT) + 200) begin
      @(posedge clk);
      waited++;
    end
    @(negedge clk);
    check("timeout_error", err_cnt, start_err + 1);
    delta = err_cyc - fall_cyc;
    check("timeout_latency", 32'(delta >= int'(TIMEOUT) && delta <= int'(TIMEOUT) + 30), 1);
    m_errs++;
    m_ext = 0;
    m_brk = 0;
    send_byte(8'h5A);
    check("enter_after_timeout", 32'(keycode), 128);

    send_bits(11'b111_1111_0110, 3);
    chk_en = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midframe_reset_keycode", 32'(keycode), 0);
    check("midframe_reset_key_event", 32'(key_event), 0);
    check("midframe_reset_frame_error", 32'(frame_error), 0);
    m_kc = 16'h0; m_ext = 0; m_brk = 0; m_shift = 0; m_held = 0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    repeat (5) @(posedge clk);
    send_byte(8'h1C);
    check("fresh_frame_after_reset", 32'(keycode), 32'h41);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
